// File: rtl/stream_sched.sv
// stream_sched: frame sequencer for the interpolator test chain.
// Clears the output FIFO, starts source and sink together, then waits for both under a watchdog.
module stream_sched #(
  parameter int CONFIG_WIDTH = 32,
  parameter int FRAME_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CONFIG_WIDTH-1:0] ilen_i,
  input  logic [CONFIG_WIDTH-1:0] olen_i,
  input  logic [FRAME_WIDTH-1:0]  nframes_i,
  input  logic [CONFIG_WIDTH-1:0] timeout_i,
  input  logic                    src_done_i,
  input  logic                    sink_done_i,
  output logic                    src_start_o,
  output logic                    sink_start_o,
  output logic [CONFIG_WIDTH-1:0] src_len_o,
  output logic [CONFIG_WIDTH-1:0] sink_len_o,
  output logic                    ip_en_o,
  output logic                    fifo_clr_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [1:0]              err_code_o,
  output logic [FRAME_WIDTH-1:0]  frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_RUN, S_FDONE, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  state_t                  state;
  logic [FRAME_WIDTH-1:0]  nframes_q;
  logic [CONFIG_WIDTH-1:0] timeout_q;
  logic [CONFIG_WIDTH-1:0] wdog;
  logic                    src_seen;
  logic                    sink_seen;

  logic [CONFIG_WIDTH-1:0] wdog_next;
  logic                    expired;
  logic                    both_done;
  logic                    bad_cfg;

  assign wdog_next = wdog + CONFIG_WIDTH'(1);
  // Saturated watchdog wraps wdog_next to 0, which never matches a non-zero limit.
  assign expired   = (timeout_q != '0) && (wdog_next == timeout_q);
  assign both_done = (src_seen | src_done_i) & (sink_seen | sink_done_i);
  assign bad_cfg   = (ilen_i == '0) || (olen_i == '0) || (nframes_i == '0);

  // Outputs are set on the edge entering each state so they are valid for that whole state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      nframes_q    <= '0;
      timeout_q    <= '0;
      wdog         <= '0;
      src_seen     <= 1'b0;
      sink_seen    <= 1'b0;
      src_start_o  <= 1'b0;
      sink_start_o <= 1'b0;
      src_len_o    <= '0;
      sink_len_o   <= '0;
      ip_en_o      <= 1'b0;
      fifo_clr_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      err_code_o   <= ERR_NONE;
      frame_cnt_o  <= '0;
    end else begin
      src_start_o  <= 1'b0;
      sink_start_o <= 1'b0;
      fifo_clr_o   <= 1'b0;
      done_o       <= 1'b0;
      if (abort_i && state != S_IDLE) begin
        state      <= S_IDLE;
        busy_o     <= 1'b0;
        ip_en_o    <= 1'b0;
        fifo_clr_o <= 1'b1;
        error_o    <= 1'b0;
        err_code_o <= ERR_NONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              src_len_o   <= ilen_i;
              sink_len_o  <= olen_i;
              nframes_q   <= nframes_i;
              timeout_q   <= timeout_i;
              frame_cnt_o <= '0;
              busy_o      <= 1'b1;
              if (bad_cfg) begin
                state      <= S_ERROR;
                error_o    <= 1'b1;
                err_code_o <= ERR_CFG;
              end else begin
                state      <= S_CLEAR;
                err_code_o <= ERR_NONE;
                fifo_clr_o <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            src_seen     <= 1'b0;
            sink_seen    <= 1'b0;
            state        <= S_ARM;
            src_start_o  <= 1'b1;
            sink_start_o <= 1'b1;
            ip_en_o      <= 1'b1;
          end
          S_ARM: begin
            wdog  <= '0;
            state <= S_RUN;
          end
          S_RUN: begin
            if (expired) begin
              state      <= S_ERROR;
              ip_en_o    <= 1'b0;
              error_o    <= 1'b1;
              err_code_o <= ERR_TIMEOUT;
            end else if (both_done) begin
              state       <= S_FDONE;
              ip_en_o     <= 1'b0;
              frame_cnt_o <= frame_cnt_o + FRAME_WIDTH'(1);
            end else begin
              src_seen  <= src_seen | src_done_i;
              sink_seen <= sink_seen | sink_done_i;
              wdog      <= (&wdog) ? wdog : wdog_next;
            end
          end
          S_FDONE: begin
            if (frame_cnt_o == nframes_q) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state      <= S_CLEAR;
              fifo_clr_o <= 1'b1;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/stream_sched.md
Name: stream_sched

Overview:
- Top-level sequencer for the interpolator test chain: stimulus source -> interpolator -> output FIFO -> sink/capture memory.
- Latches a run configuration and clears the FIFO before each frame.
- Starts the source and sink together, then waits for both completions under a watchdog.
- Repeats for N frames and reports done or error.

Parameters:
- CONFIG_WIDTH, 32, width of length/timeout configuration words
- FRAME_WIDTH, 8, width of frame count configuration and counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  run request, sampled in IDLE (level)
- abort_i  in  1  synchronous abort, any state
- ilen_i  in  CONFIG_WIDTH  input samples per frame (to source)
- olen_i  in  CONFIG_WIDTH  output samples per frame (to sink)
- nframes_i  in  FRAME_WIDTH  frames per run
- timeout_i  in  CONFIG_WIDTH  per-frame watchdog limit in cycles; 0 = disabled
- src_done_i  in  1  source finished frame (pulse or level)
- sink_done_i  in  1  sink finished frame (pulse or level)
- src_start_o  out  1  one-cycle start pulse to source
- sink_start_o  out  1  one-cycle start pulse to sink
- src_len_o  out  CONFIG_WIDTH  latched ilen
- sink_len_o  out  CONFIG_WIDTH  latched olen
- ip_en_o  out  1  interpolator enable
- fifo_clr_o  out  1  one-cycle FIFO clear
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle run-complete pulse
- error_o  out  1  high while in ERROR
- err_code_o  out  2  0 none, 1 bad config, 2 timeout
- frame_cnt_o  out  FRAME_WIDTH  frames completed in current run

Behaviour:
- Reset: all outputs 0; state IDLE; sticky flags, watchdog and frame counter 0.
- States: IDLE, CLEAR, ARM, RUN, FDONE, DONE, ERROR. All outputs are registered.
- IDLE:
  - On start_i=1, latch ilen/olen/nframes/timeout into src_len_o/sink_len_o and internal registers; clear frame_cnt_o and err_code_o.
  - If ilen_i=0, olen_i=0 or nframes_i=0, go to ERROR with err_code 1. Otherwise go to CLEAR.
  - Config inputs are ignored outside IDLE.
- CLEAR: fifo_clr_o=1 for exactly this cycle; clear both sticky done flags; go to ARM.
- ARM:
  - src_start_o=sink_start_o=1 for this cycle only; ip_en_o goes 1 in this same cycle.
  - Watchdog is set to 0; go to RUN.
- RUN:
  - ip_en_o=1. src_done_i/sink_done_i set sticky flags; they may arrive in either order or in the same cycle.
  - When both flags are set (including a flag set this cycle), go to FDONE.
  - Otherwise the watchdog increments each cycle. If timeout≠0 and watchdog+1 = timeout, go to ERROR with code 2; the timeout wins over a done arriving the same cycle.
  - Watchdog saturates at all-ones.
- FDONE:
  - ip_en_o=0; frame_cnt_o increments.
  - If new count = nframes, go to DONE, else go to CLEAR.
  - Per-frame overhead between frames is CLEAR+ARM+FDONE = 3 cycles.
- DONE: done_o=1 for one cycle; go to IDLE. frame_cnt_o holds its value until the next start.
- ERROR:
  - error_o=1, ip_en_o=0, err_code_o held.
  - Leave only via abort_i to IDLE. error_o and err_code_o clear on that transition.
  - start_i is ignored in ERROR.
- abort_i:
  - Highest priority in every non-IDLE state: go to IDLE next cycle.
  - ip_en_o drops; fifo_clr_o pulses in the abort cycle; no done_o; frame_cnt_o holds.
  - abort_i in IDLE has no effect.
- Done inputs outside RUN are ignored; they are not captured into the sticky flags.
- Reset asserted mid-run returns everything to reset values immediately; no pulses are emitted.

Test Plan:
- Nominal:
  - Stimulus: ilen=100, olen=397, nframes=1, timeout=0; src_done 120 cycles after src_start, sink_done 430 cycles after.
  - Required: fifo_clr, then start pulses in the next cycle; done_o 2 cycles after sink_done; frame_cnt=1; ip_en high from ARM through RUN.
- Multi-frame with done ordering:
  - Stimulus: nframes=3; frame 1 sink_done before src_done; frame 2 both done in the same cycle.
  - Required: exactly 3 fifo_clr and 3 start-pulse pairs; frame_cnt sequence 1, 2, 3; single done_o.
- Timeout:
  - Stimulus: timeout=50; src_done never arrives.
  - Required: ERROR 50 cycles after ARM, err_code=2, error_o held.
  - Then: start_i is ignored; abort_i returns to IDLE with error_o=0.
- Timeout/done collision:
  - Stimulus: timeout=10; both dones arrive on the expiry cycle.
  - Required: ERROR with code 2, no done_o.
- Bad config: ilen=0 or nframes=0 -> ERROR code 1 the cycle after start, no start pulses.
- Abort mid-RUN and reset mid-RUN:
  - Abort: fifo_clr pulse, IDLE, no done_o; a stale src_done arriving later is ignored; a fresh start works.
  - Reset: all outputs 0.
